// File: rtl/load_modulator_pkg.sv
// Shared definitions for the load-modulator transmitter, decoder and benches.
//   lm_state_e   : decoder FSM states (idle / receiving a frame)
//   lm_pattern_e : the three bit-period patterns a decoder can match
//   pattern_bit  : ideal tx_out level of a pattern at tick position p
package load_modulator_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRx
  } lm_state_e;

  typedef enum logic [1:0] {
    PatIdle = 2'd0,
    PatTx0  = 2'd1,
    PatTx1  = 2'd2
  } lm_pattern_e;

  // TX_1 carries the subcarrier in the first half of the bit, TX_0 in the
  // second half; IDLE is silent for the whole period.
  function automatic logic pattern_bit(input int unsigned bit_ticks,
                                       input int unsigned sc_period,
                                       input lm_pattern_e  pattern,
                                       input int unsigned  p);
    logic sc;
    logic first_half;
    logic result;
    sc         = (p % sc_period) < (sc_period / 2);
    first_half = p < (bit_ticks / 2);
    case (pattern)
      PatTx1:  result = sc & first_half;
      PatTx0:  result = sc & ~first_half;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/lm_mismatch_counter.sv
// Counts ticks in the current bit period where tx does not match one
// reference pattern.
//   clk, rst_n  : clock, asynchronous active-low reset
//   sample_en   : a tick is being sampled this cycle
//   pos         : tick position of the sample being taken
//   tx          : sampled load-modulator level
//   count_next  : mismatch count including this sample (restarts at pos 0)
module lm_mismatch_counter
  import load_modulator_pkg::*;
#(
  parameter int unsigned BIT_TICKS = 128,
  parameter int unsigned SC_PERIOD = 16,
  parameter lm_pattern_e PATTERN   = PatIdle,
  localparam int unsigned PosW     = $clog2(BIT_TICKS),
  localparam int unsigned CntW     = $clog2(BIT_TICKS) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sample_en,
  input  logic [PosW-1:0] pos,
  input  logic            tx,
  output logic [CntW-1:0] count_next
);

  logic            expected;
  logic            mismatch;
  logic [CntW-1:0] count_q;

  always_comb begin
    expected   = pattern_bit(BIT_TICKS, SC_PERIOD, PATTERN, 32'(pos));
    mismatch   = tx ^ expected;
    // Position 0 starts a fresh bit, so the stale count is dropped there.
    count_next = ((pos == '0) ? '0 : count_q) + CntW'(mismatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (sample_en) begin
      count_q <= count_next;
    end
  end

endmodule

// File: rtl/load_modulator_decoder.sv
// Decodes a subcarrier-modulated load-modulator bit stream into bits.
// A frame starts on the first high sample (SOC, must be TX_1), carries TX_0 /
// TX_1 bits and ends with a silent bit period.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : decoder enable; low forces idle without pulses
//   tx_out         : load modulator signal, one sample per clock
//   bit_valid      : one-cycle pulse, bit_data valid
//   bit_data       : decoded bit value
//   sof            : with bit_valid on the SOC bit
//   eof            : one-cycle pulse when an idle bit ends the frame
//   pattern_error  : one-cycle pulse on an unmatched bit or a bad SOC
//   bit_count      : bits decoded in the current frame (saturating)
// Build option: LOAD_MODULATOR_DECODER_TOLERANCE_EN enables MAX_ERRORS
// mismatching ticks per bit; without it every bit must match exactly.
module load_modulator_decoder
  import load_modulator_pkg::*;
#(
  parameter int unsigned BIT_TICKS  = 128,
  parameter int unsigned SC_PERIOD  = 16,
  parameter int unsigned MAX_ERRORS = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        tx_out,
  output logic        bit_valid,
  output logic        bit_data,
  output logic        sof,
  output logic        eof,
  output logic        pattern_error,
  output logic [15:0] bit_count
);

  localparam int unsigned PosW = $clog2(BIT_TICKS);
  localparam int unsigned CntW = $clog2(BIT_TICKS) + 1;

`ifdef LOAD_MODULATOR_DECODER_TOLERANCE_EN
  localparam int unsigned Tolerance = MAX_ERRORS;
`else
  localparam int unsigned Tolerance = 0;
`endif

  if ((BIT_TICKS < 16) || (BIT_TICKS > 256) || ((BIT_TICKS & (BIT_TICKS - 1)) != 0) ||
      (SC_PERIOD < 2) || ((SC_PERIOD % 2) != 0) || (((BIT_TICKS / 2) % SC_PERIOD) != 0) ||
      (MAX_ERRORS >= BIT_TICKS / 8)) begin : g_param_check
    $error("load_modulator_decoder: illegal parameter combination");
  end

  lm_state_e       state_q, state_d;
  logic [PosW-1:0] pos_q, pos_d;
  logic            first_q, first_d;
  logic [15:0]     bit_count_q, bit_count_d;
  logic            valid_q, valid_d;
  logic            data_q, data_d;
  logic            sof_q, sof_d;
  logic            eof_q, eof_d;
  logic            perr_q, perr_d;

  logic            sample_en;
  logic            last_tick;
  logic [CntW-1:0] cnt_idle, cnt_tx0, cnt_tx1;
  logic            cls_hit;
  lm_pattern_e     cls;

  // In idle only the starting sample (position 0) is counted.
  assign sample_en = (state_q == StRx) ? enable : (enable & tx_out);
  assign last_tick = (pos_q == PosW'(BIT_TICKS - 1));

  lm_mismatch_counter #(
    .BIT_TICKS (BIT_TICKS),
    .SC_PERIOD (SC_PERIOD),
    .PATTERN   (PatIdle)
  ) u_cnt_idle (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .pos        (pos_q),
    .tx         (tx_out),
    .count_next (cnt_idle)
  );

  lm_mismatch_counter #(
    .BIT_TICKS (BIT_TICKS),
    .SC_PERIOD (SC_PERIOD),
    .PATTERN   (PatTx0)
  ) u_cnt_tx0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .pos        (pos_q),
    .tx         (tx_out),
    .count_next (cnt_tx0)
  );

  lm_mismatch_counter #(
    .BIT_TICKS (BIT_TICKS),
    .SC_PERIOD (SC_PERIOD),
    .PATTERN   (PatTx1)
  ) u_cnt_tx1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .pos        (pos_q),
    .tx         (tx_out),
    .count_next (cnt_tx1)
  );

  // Tie priority IDLE > TX_0 > TX_1.
  always_comb begin
    cls_hit = 1'b1;
    cls     = PatIdle;
    if (cnt_idle <= CntW'(Tolerance)) begin
      cls = PatIdle;
    end else if (cnt_tx0 <= CntW'(Tolerance)) begin
      cls = PatTx0;
    end else if (cnt_tx1 <= CntW'(Tolerance)) begin
      cls = PatTx1;
    end else begin
      cls_hit = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    first_d     = first_q;
    bit_count_d = bit_count_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    perr_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        pos_d = '0;
        if (enable && tx_out) begin
          state_d = StRx;
          pos_d   = PosW'(1);
          first_d = 1'b1;
        end
      end
      StRx: begin
        if (!enable) begin
          state_d = StIdle;
          pos_d   = '0;
        end else if (!last_tick) begin
          pos_d = pos_q + PosW'(1);
        end else begin
          pos_d = '0;
          if (first_q) begin
            if (cls_hit && (cls == PatTx1)) begin
              valid_d     = 1'b1;
              data_d      = 1'b1;
              sof_d       = 1'b1;
              bit_count_d = 16'd1;
              first_d     = 1'b0;
            end else begin
              perr_d  = 1'b1;
              state_d = StIdle;
            end
          end else if (!cls_hit) begin
            perr_d  = 1'b1;
            state_d = StIdle;
          end else if (cls == PatIdle) begin
            eof_d   = 1'b1;
            state_d = StIdle;
          end else begin
            valid_d = 1'b1;
            data_d  = (cls == PatTx1);
            if (bit_count_q != 16'hFFFF) begin
              bit_count_d = bit_count_q + 16'd1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        pos_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pos_q       <= '0;
      first_q     <= 1'b0;
      bit_count_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      first_q     <= first_d;
      bit_count_q <= bit_count_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      perr_q      <= perr_d;
    end
  end

  assign bit_valid     = valid_q;
  assign bit_data      = data_q;
  assign sof           = sof_q;
  assign eof           = eof_q;
  assign pattern_error = perr_q;
  assign bit_count     = bit_count_q;

endmodule

// File: doc/load_modulator_decoder.md
LOAD_MODULATOR_DECODER -- requirements
Module: load_modulator_decoder

Interface
REQ-001 SHALL have parameter BIT_TICKS, default 128, meaning ticks per bit period; power of two, 16..256.
REQ-002 SHALL have parameter SC_PERIOD, default 16, meaning subcarrier period in ticks; even, divides BIT_TICKS/2.
REQ-003 SHALL have parameter MAX_ERRORS, default 0, meaning mismatching ticks tolerated per bit; must be < BIT_TICKS/8.
REQ-004 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port enable  input  1  decoder enable; low forces IDLE.
REQ-007 SHALL have port tx_out  input  1  load modulator signal.
REQ-008 SHALL have port bit_valid  output  1  one-cycle pulse, bit_data valid; no backpressure.
REQ-009 SHALL have port bit_data  output  1  decoded bit value.
REQ-010 SHALL have port sof  output  1  high with bit_valid on the first (SOC) bit of a frame.
REQ-011 SHALL have port eof  output  1  one-cycle pulse when an idle bit period ends a frame.
REQ-012 SHALL have port pattern_error  output  1  one-cycle pulse on an invalid bit period or a bad SOC.
REQ-013 SHALL have port bit_count  output  16  bits decoded in the current frame, SOC included.

Function
REQ-014 SHALL implement the states IDLE and RX.
REQ-015 SHALL go IDLE->RX on the edge sampling tx_out=1 with enable=1; that sample is tick position 0.
REQ-016 SHALL in RX advance the position 0..BIT_TICKS-1, then wrap to 0 with no gap ticks.
REQ-017 SHALL define subcarrier sc(p)=1 when (p mod SC_PERIOD) < SC_PERIOD/2.
REQ-018 SHALL define the bit patterns per position p as follows.
- TX_1 = sc(p) for p < BIT_TICKS/2, else 0.
- TX_0 = 0 for p < BIT_TICKS/2, else sc(p).
- IDLE = 0 at all positions.
REQ-019 SHALL keep three mismatch counters (vs IDLE, TX_0, TX_1), each sized clog2(BIT_TICKS)+1, cleared at position 0.
REQ-020 SHALL classify a bit using counts that include the position BIT_TICKS-1 sample; a pattern matches when count <= tolerance.
REQ-021 SHALL resolve a classification tie with priority IDLE > TX_0 > TX_1.
REQ-022 SHALL drive outputs in the cycle after the last tick of a bit was sampled (latency 1).
REQ-023 SHALL on a TX_0 or TX_1 match pulse bit_valid, set bit_data, and increment bit_count (saturating at 16'hFFFF).
REQ-024 SHALL, for the first bit of a frame, pulse sof, load bit_count=1, and pulse pattern_error instead (then IDLE) if that bit is not TX_1.
REQ-025 SHALL on an IDLE match pulse eof and go IDLE; bit_valid stays low.
REQ-026 SHALL on no match pulse pattern_error and go IDLE; the frame is aborted with no eof.
REQ-027 SHALL allow a new frame to start on the cycle after a return to IDLE.
REQ-028 SHALL when enable falls in RX go IDLE next cycle and produce no pulses; bit_count holds.
REQ-029 SHALL never assert bit_valid, eof and pattern_error together.

Reset
REQ-030 SHALL while rst_n=0 hold state IDLE, position and counters 0, and all outputs 0, including bit_count.
REQ-031 SHALL, when reset is asserted mid-frame, discard the partial bit; no pulses after release.

Configuration
REQ-032 SHALL honour the macro LOAD_MODULATOR_DECODER_TOLERANCE_EN as follows.
- Defined: tolerance = MAX_ERRORS.
- Undefined: tolerance = 0 (exact match) and MAX_ERRORS is ignored.

Structure
REQ-033 SHALL place the state enum and a pattern-bit function (BIT_TICKS, SC_PERIOD, pattern, p) in package load_modulator_pkg, shared with the transmitter and benches.
REQ-034 SHALL use sub-module lm_mismatch_counter, instantiated three times (IDLE, TX_0, TX_1), holding the position compare and its counter.

Verification
REQ-035 SHALL cover: frame SOC,1,0,1 then idle (defaults) -> bit_valid x4 with data 1,1,0,1; sof on the first; bit_count 4; eof 128 ticks after the last bit.
REQ-036 SHALL cover: SOC then one TX_1 with tick 70 high (tolerance off) -> pattern_error at that bit, return to IDLE, no eof.
REQ-037 SHALL cover: as the previous case with the macro defined and MAX_ERRORS=2 -> bit accepted as 0 or 1 per the pattern, no error.
REQ-038 SHALL cover: first bit TX_0 after a stray rising edge -> pattern_error with sof low.
REQ-039 SHALL cover: enable dropped mid-bit 2, or rst_n pulsed mid-bit -> IDLE, no pulses; the next frame decodes correctly.
REQ-040 SHALL cover: BIT_TICKS=64, SC_PERIOD=8, frame SOC,0 -> two bit_valid pulses 64 ticks apart, then eof.
